// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multicycle control FSM: states, instruction
// classes, opcodes, funct3 values and ALU operation codes.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_TRAP   = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        CLS_R   = 3'd0,
        CLS_I   = 3'd1,
        CLS_LW  = 3'd2,
        CLS_SW  = 3'd3,
        CLS_BEQ = 3'd4,
        CLS_BNE = 3'd5,
        CLS_JAL = 3'd6,
        CLS_ILL = 3'd7
    } cls_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_SW   = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    function automatic cls_t classify(input logic [6:0] opcode, input logic [2:0] funct3);
        cls_t cls;
        cls = CLS_ILL;
        unique case (opcode)
            OP_R:    cls = CLS_R;
            OP_I:    cls = CLS_I;
            OP_LW:   cls = (funct3 == F3_LW) ? CLS_LW : CLS_ILL;
            OP_SW:   cls = (funct3 == F3_SW) ? CLS_SW : CLS_ILL;
            OP_BR: begin
                if (funct3 == F3_BEQ)      cls = CLS_BEQ;
                else if (funct3 == F3_BNE) cls = CLS_BNE;
                else                       cls = CLS_ILL;
            end
            OP_JAL:  cls = CLS_JAL;
            default: cls = CLS_ILL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation decode from instruction class, funct3 and funct7[5].
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [2:0] i_cls,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    output logic [3:0] o_alucontrol
);

    logic [3:0] w_arith;
    logic       w_is_r;

    assign w_is_r = (i_cls == CLS_R);

    // funct7[5] selects SUB only for R-type; SRA/SRAI use it in both formats.
    always_comb begin
        w_arith = ALU_ADD;
        unique case (i_funct3)
            F3_ADD:  w_arith = (w_is_r && i_funct7b5) ? ALU_SUB : ALU_ADD;
            F3_SLL:  w_arith = ALU_SLL;
            F3_SLT:  w_arith = ALU_SLT;
            F3_SLTU: w_arith = ALU_SLTU;
            F3_XOR:  w_arith = ALU_XOR;
            F3_SR:   w_arith = i_funct7b5 ? ALU_SRA : ALU_SRL;
            F3_OR:   w_arith = ALU_OR;
            F3_AND:  w_arith = ALU_AND;
            default: w_arith = ALU_ADD;
        endcase
    end

    always_comb begin
        o_alucontrol = ALU_ADD;
        unique case (i_cls)
            CLS_R, CLS_I:     o_alucontrol = w_arith;
            CLS_BEQ, CLS_BNE: o_alucontrol = ALU_SUB;
            default:          o_alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: FETCH/DECODE/EXEC/MEM/TRAP with imem/dmem handshakes.
// Optional retired-instruction counter enabled by defining CTRL_INSTRET_EN.
module multicycle_ctrl
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        zero,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic        pcwrite,
    output logic        irwrite,
    output logic        memtoreg,
    output logic        brtaken,
    output logic        alusrcimm,
    output logic        writesreg,
    output logic        jump,
    output logic        splitimm,
    output logic [3:0]  alucontrol,
    output logic        illegal,
    output logic [31:0] instret
);

    state_t     r_state;
    state_t     w_state_next;
    logic [6:0] r_opcode;
    logic [2:0] r_funct3;
    logic       r_funct7b5;
    cls_t       w_cls;
    logic [3:0] w_alu;
    logic       w_unused_instr;

    assign w_unused_instr = ^{instr[31], instr[29:15], instr[11:7]};
    assign w_cls          = classify(r_opcode, r_funct3);

    alu_decoder u_alu_decoder (
        .i_cls        (w_cls),
        .i_funct3     (r_funct3),
        .i_funct7b5   (r_funct7b5),
        .o_alucontrol (w_alu)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_opcode   <= '0;
            r_funct3   <= '0;
            r_funct7b5 <= 1'b0;
        end else if (irwrite) begin
            r_opcode   <= instr[6:0];
            r_funct3   <= instr[14:12];
            r_funct7b5 <= instr[30];
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_FETCH:  if (imem_ack) w_state_next = ST_DECODE;
            ST_DECODE: w_state_next = (w_cls == CLS_ILL) ? ST_TRAP : ST_EXEC;
            ST_EXEC:   w_state_next = (w_cls == CLS_LW || w_cls == CLS_SW) ? ST_MEM : ST_FETCH;
            ST_MEM:    if (dmem_ack) w_state_next = ST_FETCH;
            ST_TRAP:   w_state_next = ST_TRAP;
            default:   w_state_next = ST_FETCH;
        endcase
    end

    // Outputs are gated by reset so requests drop the instant reset asserts.
    always_comb begin
        imem_req   = 1'b0;
        irwrite    = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        pcwrite    = 1'b0;
        memtoreg   = 1'b0;
        brtaken    = 1'b0;
        alusrcimm  = 1'b0;
        writesreg  = 1'b0;
        jump       = 1'b0;
        splitimm   = 1'b0;
        alucontrol = ALU_ADD;
        illegal    = 1'b0;
        if (reset) begin
            unique case (r_state)
                ST_FETCH: begin
                    imem_req = 1'b1;
                    irwrite  = imem_ack;
                end
                ST_EXEC: begin
                    alucontrol = w_alu;
                    unique case (w_cls)
                        CLS_R: begin
                            writesreg = 1'b1;
                            pcwrite   = 1'b1;
                        end
                        CLS_I: begin
                            writesreg = 1'b1;
                            pcwrite   = 1'b1;
                            alusrcimm = 1'b1;
                        end
                        CLS_LW: alusrcimm = 1'b1;
                        CLS_SW: begin
                            alusrcimm = 1'b1;
                            splitimm  = 1'b1;
                        end
                        CLS_BEQ: begin
                            pcwrite = 1'b1;
                            brtaken = zero;
                        end
                        CLS_BNE: begin
                            pcwrite = 1'b1;
                            brtaken = !zero;
                        end
                        CLS_JAL: begin
                            jump    = 1'b1;
                            pcwrite = 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_MEM: begin
                    dmem_req   = 1'b1;
                    dmem_we    = (w_cls == CLS_SW);
                    alusrcimm  = 1'b1;
                    splitimm   = (w_cls == CLS_SW);
                    alucontrol = ALU_ADD;
                    pcwrite    = dmem_ack;
                    writesreg  = dmem_ack && (w_cls == CLS_LW);
                    memtoreg   = dmem_ack && (w_cls == CLS_LW);
                end
                ST_TRAP: illegal = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef CTRL_INSTRET_EN
    logic [31:0] r_instret;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_instret <= '0;
        end else if (pcwrite) begin
            r_instret <= r_instret + 32'd1;
        end
    end

    assign instret = r_instret;
`else
    assign instret = 32'd0;
`endif

endmodule
